// File: rtl/sdf_delay_buffer.sv
// Circular Re/Im delay line: oData is the sample accepted DEPTH enables earlier, always registered.
// No backpressure: one sample per iEn cycle; with iEn low every register and the memory hold.
module sdf_delay_buffer #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic [WIDTH-1:0] iData_Re,
  input  logic [WIDTH-1:0] iData_Im,
  output logic [WIDTH-1:0] oData_Re,
  output logic [WIDTH-1:0] oData_Im,
  output logic             oValid,
  output logic             oPhase
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]   ptr;
  logic               primed;
  logic               wrap;
  logic               wrEn;
  logic [2*WIDTH-1:0] rdWord;

  assign wrap = (ptr == LAST);
  assign wrEn = iEn && !iRst;

  // Stale contents are harmless: every slot is rewritten before primed can rise.
  generate
    if (DEPTH == 1) begin : gSingle
      logic [2*WIDTH-1:0] mem;
      always_ff @(posedge iClk) begin
        if (wrEn) mem <= {iData_Re, iData_Im};
      end
      assign rdWord = mem;
    end else begin : gRam
      logic [2*WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge iClk) begin
        if (wrEn) mem[ptr] <= {iData_Re, iData_Im};
      end
      assign rdWord = mem[ptr];
    end
  endgenerate

  // The fill count reaches DEPTH exactly on the first wrap, so a single flag replaces it.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      ptr      <= '0;
      primed   <= 1'b0;
      oValid   <= 1'b0;
      oPhase   <= 1'b0;
      oData_Re <= '0;
      oData_Im <= '0;
    end else if (iEn) begin
      if (primed) begin
        {oData_Re, oData_Im} <= rdWord;
        oValid               <= 1'b1;
      end else begin
        oData_Re <= '0;
        oData_Im <= '0;
        oValid   <= 1'b0;
      end
      if (wrap) begin
        ptr    <= '0;
        oPhase <= ~oPhase;
        primed <= 1'b1;
      end else begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sdf_delay_buffer.sv
// Three depths (4, 1, 3) share one stimulus stream; a history-array model feeds a scoreboard queue.
module tb_sdf_delay_buffer;

  localparam int W  = 38;
  localparam int ND = 3;

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         v;
    logic         ph;
  } exp_t;
  typedef exp_t [ND-1:0] expv_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [W-1:0] re  = '0;
  logic [W-1:0] im  = '0;

  logic [W-1:0] oRe0, oIm0, oRe1, oIm1, oRe2, oIm2;
  logic         oV0, oP0, oV1, oP1, oV2, oP2;

  always #5 clk = ~clk;

  sdf_delay_buffer #(.WIDTH(W), .DEPTH(4)) dut4 (
    .iClk(clk), .iRst(rst), .iEn(en), .iData_Re(re), .iData_Im(im),
    .oData_Re(oRe0), .oData_Im(oIm0), .oValid(oV0), .oPhase(oP0));
  sdf_delay_buffer #(.WIDTH(W), .DEPTH(1)) dut1 (
    .iClk(clk), .iRst(rst), .iEn(en), .iData_Re(re), .iData_Im(im),
    .oData_Re(oRe1), .oData_Im(oIm1), .oValid(oV1), .oPhase(oP1));
  sdf_delay_buffer #(.WIDTH(W), .DEPTH(3)) dut3 (
    .iClk(clk), .iRst(rst), .iEn(en), .iData_Re(re), .iData_Im(im),
    .oData_Re(oRe2), .oData_Im(oIm2), .oValid(oV2), .oPhase(oP2));

  function automatic int depthOf(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  // Reference model: every sample accepted since reset, in order.
  logic [2*W-1:0] hist [0:4095];
  int             cnt = 0;
  expv_t          cur = '0;
  expv_t          expQ [$];

  int tests  = 0;
  int fails  = 0;
  int cycle  = 0;

  task automatic step(input logic r, input logic e, input logic [W-1:0] a, input logic [W-1:0] b);
    int dep;
    @(negedge clk);
    rst = r; en = e; re = a; im = b;
    for (int d = 0; d < ND; d++) begin
      dep = depthOf(d);
      if (r) begin
        cur[d] = '0;
      end else if (e) begin
        if (cnt >= dep) begin
          {cur[d].re, cur[d].im} = hist[cnt - dep];
          cur[d].v = 1'b1;
        end else begin
          cur[d].re = '0;
          cur[d].im = '0;
          cur[d].v  = 1'b0;
        end
        cur[d].ph = (((cnt + 1) / dep) % 2) == 1;
      end
    end
    if (r) begin
      cnt = 0;
    end else if (e) begin
      hist[cnt] = {a, b};
      cnt++;
    end
    expQ.push_back(cur);
    @(posedge clk);
  endtask

  // Monitor: outputs are registered, so each edge presents one response to score.
  initial begin
    expv_t e;
    exp_t  got [ND];
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      got[0] = '{re: oRe0, im: oIm0, v: oV0, ph: oP0};
      got[1] = '{re: oRe1, im: oIm1, v: oV1, ph: oP1};
      got[2] = '{re: oRe2, im: oIm2, v: oV2, ph: oP2};
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        for (int d = 0; d < ND; d++) begin
          tests++;
          if (got[d] !== e[d]) begin
            fails++;
            $display("FAIL out_depth%0d cycle %0d: got re=%h im=%h v=%b ph=%b, want re=%h im=%h v=%b ph=%b",
                     depthOf(d), cycle, got[d].re, got[d].im, got[d].v, got[d].ph,
                     e[d].re, e[d].im, e[d].v, e[d].ph);
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] a, b;
    // Reset, then idle.
    step(1, 0, '0, '0);
    step(1, 1, '1, '1);
    for (int i = 0; i < 5; i++) step(0, 0, W'(i + 7), W'(i + 9));
    // Continuous fill: Re=k, Im=-k.
    for (int k = 1; k <= 12; k++) step(0, 1, W'(k), W'(-k));
    // Enable gaps after a fresh reset.
    step(1, 0, '0, '0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, W'(k), W'(-k));
      step(0, 0, W'(k + 50), W'(k + 60));
      step(0, 0, W'(k + 70), W'(k + 80));
    end
    // Reset mid-operation with iEn high, then re-prime.
    step(1, 0, '0, '0);
    for (int k = 1; k <= 6; k++) step(0, 1, W'(k + 200), W'(k + 300));
    step(1, 1, W'(999), W'(998));
    for (int k = 1; k <= 6; k++) step(0, 1, W'(k + 400), W'(k + 500));
    // Short sequence A, B, C then 100..109 with full-scale values mixed in.
    step(1, 0, '0, '0);
    step(0, 1, W'('hA), W'('hA));
    step(0, 1, W'('hB), W'('hB));
    step(0, 1, W'('hC), W'('hC));
    step(1, 0, '0, '0);
    for (int k = 0; k < 10; k++) begin
      a = W'(100 + k);
      b = (k % 2 == 0) ? 38'h3F_FFFF_FFFF : 38'h20_0000_0000;
      step(0, 1, a, b);
    end
    step(0, 1, 38'h20_0000_0000, 38'h3F_FFFF_FFFF);
    step(0, 1, 38'h3F_FFFF_FFFF, 38'h20_0000_0000);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 5))
        0:       a = 38'h3F_FFFF_FFFF;
        1:       a = 38'h20_0000_0000;
        default: a = W'({$urandom(), $urandom()});
      endcase
      b = W'({$urandom(), $urandom()});
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), a, b);
    end
    step(0, 0, '0, '0);
    @(posedge clk);
    #2;
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdf_delay_buffer.md
Name: sdf_delay_buffer

Overview:
Parametrised complex-sample delay line for the R2SDF FFT feedback path. It generalises the single-register stage buffer to a depth of DEPTH samples. Every enabled cycle it writes one Re/Im pair and emits the pair written DEPTH enabled cycles earlier. It also flags when its output holds real data, and provides the butterfly/bypass phase toggle the stage controller needs.

Parameters:
WIDTH, 38, bit width of each of the Re and Im components
DEPTH, 1, delay in enabled samples; legal values are integers >= 1; N/2^(s+1) for stage s
PTR_W, $clog2(DEPTH) (minimum 1), pointer width; derived, not overridden

Ports:
iClk  input  1  clock; all state updates on the rising edge
iRst  input  1  synchronous active-high reset
iEn  input  1  sample enable; one sample is accepted per high cycle
iData_Re  input  WIDTH  real part of incoming sample
iData_Im  input  WIDTH  imaginary part of incoming sample
oData_Re  output  WIDTH  real part of sample delayed by DEPTH enables (registered)
oData_Im  output  WIDTH  imaginary part of the delayed sample (registered)
oValid  output  1  high when oData holds a genuine sample (buffer primed)
oPhase  output  1  toggles each time DEPTH samples have been accepted; selects butterfly/bypass

Behaviour:
- Storage: DEPTH x (2*WIDTH) circular memory with write/read pointer ptr. The memory is not reset.
- Reset (iRst=1 at a rising edge): ptr=0, fill=0, oValid=0, oPhase=0, oData_Re=0, oData_Im=0. Reset has priority over iEn in the same cycle.
- Mid-operation reset discards all history. After reset, the buffer must be re-primed with DEPTH enables.
- When iEn=0: all state holds, outputs hold, memory unchanged.
- When iEn=1 and not in reset, on the same edge:
  - Read before write: if primed (fill==DEPTH), then oData <= mem[ptr] and oValid <= 1. Otherwise oData <= 0 and oValid <= 0.
  - mem[ptr] <= {iData_Re, iData_Im}.
  - fill <= min(fill+1, DEPTH). fill saturates at DEPTH.
  - If ptr==DEPTH-1: ptr <= 0 and oPhase <= ~oPhase. Otherwise ptr <= ptr+1.
- Latency: a sample accepted at enable k appears on oData after the edge of enable k+DEPTH. Latency is counted in enables, not clocks; gaps in iEn stretch it.
- oValid first rises on the edge of enable number DEPTH+1 after reset. It then stays high until the next reset.
- DEPTH=1: ptr is constant 0 and oPhase toggles on every enable. Data behaviour matches a single enabled register, except that oData is 0 and oValid is 0 for the first enable.
- DEPTH not a power of two: ptr wraps explicitly at DEPTH-1 and never indexes past DEPTH-1.
- Data is passed through untouched. There is no arithmetic, rounding or sign handling.
- Outputs are driven only from registers. There is no combinational path from input to output.

Test Plan:
- Reset/idle, DEPTH=4: assert iRst 2 cycles, then iEn=0 for 5 cycles -> oData_Re=oData_Im=0, oValid=0, oPhase=0 throughout.
- Fill and latency, DEPTH=4, WIDTH=38: continuous iEn with Re=1..12, Im=-1..-12 -> enables 1-4 give oData=0, oValid=0. Enable 5 gives Re=1/Im=-1 with oValid=1. Enable 12 gives Re=8/Im=-8. oPhase toggles after enables 4, 8 and 12.
- Enable gaps, DEPTH=4: feed 1..8 with iEn toggling 1,0,0,1,... -> output sequence identical to the previous test. Outputs hold during iEn=0. oPhase changes only on enabled edges.
- Reset mid-operation: after 6 enables, assert iRst together with iEn=1 -> reset wins; outputs 0, oValid=0, oPhase=0. The next 4 enables output 0. The 5th outputs the first post-reset sample; no pre-reset data ever reappears.
- DEPTH=1: inputs 0xA, 0xB, 0xC on consecutive enables -> oData 0, 0xA, 0xB. oValid is 0, 1, 1. oPhase is 1, 0, 1.
- DEPTH=3 (non-power-of-two): 10 enables with inputs 100..109 -> output at enable n equals input n-3 for n>=4. ptr never exceeds 2. oPhase toggles after enables 3, 6 and 9. Full-scale values 0x3F_FFFF_FFFF and 0x20_0000_0000 pass through bit-exact.
